// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared widths and vector-table type for the 2-bit adder
package adder_pkg;

  localparam int OPERAND_W = 2;
  localparam int SUM_W     = 3;

  // One row of an (a, b, sum) vector table.
  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    logic [SUM_W-1:0]     sum;
  } add_vec_t;

endpackage

// File: rtl/full_adder_1_bit.sv
// rtl/full_adder_1_bit.sv - single-bit full adder cell
module full_adder_1_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry; with cin tied low this degenerates to a half add.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/full_adder_2_bit_to_3_bit.sv
// rtl/full_adder_2_bit_to_3_bit.sv - 2-bit + 2-bit ripple adder with registered copy and carry counter
module full_adder_2_bit_to_3_bit
  import adder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  input  logic                 in_valid,
  output logic [SUM_W-1:0]     sum,
  output logic [SUM_W-1:0]     sum_q,
  output logic                 out_valid,
  output logic [CNT_W-1:0]     carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic carry0;
  logic carry1;
  logic s0;
  logic s1;

  logic [SUM_W-1:0] sum_d;
  logic             out_valid_d;
  logic             out_valid_q;
  logic [CNT_W-1:0] carry_cnt_d;
  logic [CNT_W-1:0] carry_cnt_q;

  full_adder_1_bit u_bit0 (
    .a    (a[0]),
    .b    (b[0]),
    .cin  (1'b0),
    .s    (s0),
    .cout (carry0)
  );

  full_adder_1_bit u_bit1 (
    .a    (a[1]),
    .b    (b[1]),
    .cin  (carry0),
    .s    (s1),
    .cout (carry1)
  );

  // The final carry becomes the MSB so no carry is ever lost.
  assign sum = {carry1, s1, s0};

  // Capture on valid, hold otherwise; count carries up to saturation.
  always_comb begin
    sum_d       = sum_q;
    out_valid_d = in_valid;
    carry_cnt_d = carry_cnt_q;
    if (in_valid) begin
      sum_d = sum;
      if (sum[2] && (carry_cnt_q != CNT_MAX)) begin
        carry_cnt_d = carry_cnt_q + CNT_ONE;
      end
    end
  end

  // Registered path state; reset clears it immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      carry_cnt_q <= '0;
    end else begin
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_full_adder_2_bit_to_3_bit.sv
// tb/tb_full_adder_2_bit_to_3_bit.sv - self-checking bench for the 2-bit adder
module tb_full_adder_2_bit_to_3_bit;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n;
  logic [1:0] a = 2'd0;
  logic [1:0] b = 2'd0;
  logic       in_valid = 1'b0;

  logic [2:0] sum;
  logic [2:0] sum_q;
  logic       out_valid;
  logic [7:0] carry_cnt;

  logic [2:0] sat_sum;
  logic [2:0] sat_sum_q;
  logic       sat_out_valid;
  logic [1:0] sat_carry_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (plain integers)
  int m_sum_q;
  int m_valid;
  int m_cnt;
  int m_cnt_sat;

  full_adder_2_bit_to_3_bit u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum),
    .sum_q     (sum_q),
    .out_valid (out_valid),
    .carry_cnt (carry_cnt)
  );

  full_adder_2_bit_to_3_bit #(.CNT_W(2)) u_dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sat_sum),
    .sum_q     (sat_sum_q),
    .out_valid (sat_out_valid),
    .carry_cnt (sat_carry_cnt)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic model_reset();
    m_sum_q = 0; m_valid = 0; m_cnt = 0; m_cnt_sat = 0;
  endtask

  task automatic model_edge(input int ai, input int bi, input int v);
    int s;
    s = ai + bi;
    m_valid = v;
    if (v != 0) begin
      m_sum_q = s;
      if (s >= 4) begin
        if (m_cnt < 255) m_cnt = m_cnt + 1;
        if (m_cnt_sat < 3) m_cnt_sat = m_cnt_sat + 1;
      end
    end
  endtask

  task automatic check_regs(input string tag);
    n_cmp++;
    if (sum_q !== 3'(m_sum_q)) begin
      n_err++; $display("FAIL %s sum_q got=%0d exp=%0d", tag, sum_q, m_sum_q);
    end
    n_cmp++;
    if (out_valid !== 1'(m_valid)) begin
      n_err++; $display("FAIL %s out_valid got=%0b exp=%0d", tag, out_valid, m_valid);
    end
    n_cmp++;
    if (carry_cnt !== 8'(m_cnt)) begin
      n_err++; $display("FAIL %s carry_cnt got=%0d exp=%0d", tag, carry_cnt, m_cnt);
    end
    n_cmp++;
    if (sat_carry_cnt !== 2'(m_cnt_sat)) begin
      n_err++; $display("FAIL %s sat_carry_cnt got=%0d exp=%0d", tag, sat_carry_cnt, m_cnt_sat);
    end
  endtask

  task automatic step(input int ai, input int bi, input int v, input string tag);
    a = 2'(ai); b = 2'(bi); in_valid = 1'(v);
    @(posedge clk); #1;
    model_edge(ai, bi, v);
    check_regs(tag);
  endtask

  task automatic test_comb();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a = 2'(i); b = 2'(j);
        #1;
        n_cmp++;
        if (sum !== 3'(i + j)) begin
          n_err++; $display("FAIL comb a=%0d b=%0d sum got=%0d exp=%0d", i, j, sum, i + j);
        end
        n_cmp++;
        if (sat_sum !== 3'(i + j)) begin
          n_err++; $display("FAIL comb_sat a=%0d b=%0d sum got=%0d exp=%0d", i, j, sat_sum, i + j);
        end
      end
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("reset");
    @(posedge clk); #1;
    check_regs("reset_held");
    rst_n = 1'b1;
  endtask

  task automatic test_registered();
    test_reset();
    step(2, 2, 1, "reg_capture");
    step(1, 0, 0, "reg_hold");
  endtask

  task automatic test_carry_count();
    test_reset();
    step(1, 1, 1, "carry_0");
    step(3, 1, 1, "carry_1");
    step(2, 3, 1, "carry_2");
    step(0, 3, 1, "carry_3");
    n_cmp++;
    if (carry_cnt !== 8'd2 || sum_q !== 3'b011) begin
      n_err++; $display("FAIL carry_final cnt=%0d sum_q=%0d exp cnt=2 sum_q=3", carry_cnt, sum_q);
    end
  endtask

  task automatic test_saturation();
    test_reset();
    for (int i = 1; i <= 5; i++) begin
      step(3, 3, 1, "sat");
      if (i >= 3) begin
        n_cmp++;
        if (sat_carry_cnt !== 2'd3) begin
          n_err++; $display("FAIL sat_max iter=%0d got=%0d exp=3", i, sat_carry_cnt);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    test_reset();
    step(3, 2, 1, "ar_pre0");
    step(2, 3, 1, "ar_pre1");
    a = 2'd3; b = 2'd1; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("ar_immediate");
    n_cmp++;
    if (sum !== 3'd4) begin
      n_err++; $display("FAIL ar_sum got=%0d exp=4", sum);
    end
    a = 2'd2; b = 2'd3;
    #1;
    n_cmp++;
    if (sum !== 3'd5) begin
      n_err++; $display("FAIL ar_sum_track got=%0d exp=5", sum);
    end
    @(posedge clk); #1;
    check_regs("ar_edge_in_reset");
    rst_n = 1'b1;
    step(2, 3, 1, "ar_first_capture");
  endtask

  task automatic test_back_to_back();
    int ai, bi, v;
    test_reset();
    for (int i = 0; i < 300; i++) begin
      ai = int'($urandom_range(3, 0));
      bi = int'($urandom_range(3, 0));
      v  = ($urandom_range(3, 0) != 0) ? 1 : 0;
      step(ai, bi, v, "rand");
    end
  endtask

  initial begin
    test_comb();
    clk_en = 1'b1;
    test_registered();
    test_carry_count();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
